// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller family.
package ssd_pkg;

    localparam int NUM_DIGITS = 8;

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_e;

    // One full display image: nibbles, enables, decimal points, blink selects.
    typedef struct packed {
        logic [31:0] digits;
        logic [7:0]  en;
        logic [7:0]  dp;
        logic [7:0]  blink;
    } disp_content_t;

    // Active-low segment patterns, bit 6 = segment a ... bit 0 = segment g.
    localparam logic [6:0] HEX_0 = 7'b0000001;
    localparam logic [6:0] HEX_1 = 7'b1001111;
    localparam logic [6:0] HEX_2 = 7'b0010010;
    localparam logic [6:0] HEX_3 = 7'b0000110;
    localparam logic [6:0] HEX_4 = 7'b1001100;
    localparam logic [6:0] HEX_5 = 7'b0100100;
    localparam logic [6:0] HEX_6 = 7'b0100000;
    localparam logic [6:0] HEX_7 = 7'b0001111;
    localparam logic [6:0] HEX_8 = 7'b0000000;
    localparam logic [6:0] HEX_9 = 7'b0000100;
    localparam logic [6:0] HEX_A = 7'b0001000;
    localparam logic [6:0] HEX_B = 7'b1100000;
    localparam logic [6:0] HEX_C = 7'b0110001;
    localparam logic [6:0] HEX_D = 7'b1000010;
    localparam logic [6:0] HEX_E = 7'b0110000;
    localparam logic [6:0] HEX_F = 7'b0111000;

endpackage

// File: rtl/ssd_scan_controller_if.sv
// Content-load port of the scan controller, plus a read-only view of the scan FSM.
interface ssd_scan_controller_if;
    import ssd_pkg::*;

    // Requester raises load_req with stable data and holds both until it sees the
    // one-cycle load_ack; the controller acks only when its shadow register is free.
    logic        load_req;
    logic [31:0] digits_in;
    logic [7:0]  digit_en_in;
    logic [7:0]  dp_in;
    logic [7:0]  blink_mask_in;
    logic        load_ack;
    scan_state_e dbg_state;

    modport master (
        output load_req, digits_in, digit_en_in, dp_in, blink_mask_in,
        input  load_ack, dbg_state
    );

    modport slave (
        input  load_req, digits_in, digit_en_in, dp_in, blink_mask_in,
        output load_ack, dbg_state
    );

endinterface

// File: rtl/ssd_hex_decoder.sv
// Hex nibble to active-low seven-segment pattern ({a..g}, a in bit 6).
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = HEX_F;
        case (hex_i)
            4'h0: seg_o = HEX_0;
            4'h1: seg_o = HEX_1;
            4'h2: seg_o = HEX_2;
            4'h3: seg_o = HEX_3;
            4'h4: seg_o = HEX_4;
            4'h5: seg_o = HEX_5;
            4'h6: seg_o = HEX_6;
            4'h7: seg_o = HEX_7;
            4'h8: seg_o = HEX_8;
            4'h9: seg_o = HEX_9;
            4'hA: seg_o = HEX_A;
            4'hB: seg_o = HEX_B;
            4'hC: seg_o = HEX_C;
            4'hD: seg_o = HEX_D;
            4'hE: seg_o = HEX_E;
            default: seg_o = HEX_F;
        endcase
    end

endmodule

// File: rtl/ssd_scan_controller.sv
// 8-digit multiplexed seven-segment driver with blanking, blink and tear-free loads.
// Optional macro SSD_DIMMING_EN adds a 3-bit brightness input (PWM within each DRIVE slot).
module ssd_scan_controller
    import ssd_pkg::*;
#(
    parameter int SCAN_DIV_W   = 18,
    parameter int BLANK_CYCLES = 64,
    parameter int BLINK_DIV_W  = 25
) (
    input  logic                    ClkPort,
    input  logic                    reset,
    ssd_scan_controller_if.slave    ld,
    input  logic                    blink_en,
`ifdef SSD_DIMMING_EN
    input  logic [2:0]              brightness,
`endif
    output logic [7:0]              An,
    output logic [6:0]              Cath,
    output logic                    Dp,
    output logic                    frame_start
);

    localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);

    scan_state_e            state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [SCAN_DIV_W-1:0]  presc_q, presc_d;
    logic [BLANK_W-1:0]     blank_q, blank_d;
    logic [BLINK_DIV_W-1:0] blink_q;
    disp_content_t          active_q, pending_q, load_in;
    logic                   pend_full_q;
    logic                   commit, capture;
    logic                   load_ack_q;
    logic [7:0]             an_q, an_d;
    logic [6:0]             cath_q, cath_d, seg;
    logic                   dp_q, dp_d, fs_q, fs_d;
    logic                   lit, blink_dark, dim_on;

    assign load_in = {ld.digits_in, ld.digit_en_in, ld.dp_in, ld.blink_mask_in};
    // A commit always clears pending_full, so capture waits one cycle behind it.
    assign capture = ld.load_req && !pend_full_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        presc_d = presc_q + 1'b1;
        blank_d = blank_q;
        commit  = 1'b0;
        case (state_q)
            ST_DRIVE: begin
                if (presc_q == '1) begin
                    state_d = ST_BLANK;
                    blank_d = '0;
                end
            end
            ST_BLANK: begin
                presc_d = '0;
                if (blank_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    idx_d   = idx_q + 3'd1;
                    blank_d = '0;
                    commit  = (idx_q == 3'd7) && pend_full_q;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

`ifdef SSD_DIMMING_EN
    assign dim_on = (presc_q[SCAN_DIV_W-1 -: 3] <= brightness);
`else
    assign dim_on = 1'b1;
`endif

    ssd_hex_decoder u_hex_decoder (
        .hex_i (active_q.digits[{idx_q, 2'b00} +: 4]),
        .seg_o (seg)
    );

    // A disabled or blinked-off digit still owns its slot, keeping frame timing fixed.
    assign blink_dark = blink_en && active_q.blink[idx_q] && blink_q[BLINK_DIV_W-1];
    assign lit        = (state_q == ST_DRIVE) && active_q.en[idx_q] && !blink_dark && dim_on;

    always_comb begin
        an_d   = 8'hFF;
        cath_d = 7'h7F;
        dp_d   = 1'b1;
        if (lit) begin
            an_d   = ~(8'b1 << idx_q);
            cath_d = seg;
            dp_d   = ~active_q.dp[idx_q];
        end
        fs_d = (state_q == ST_DRIVE) && (idx_q == 3'd0) && (presc_q == '0);
    end

    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            state_q     <= ST_BLANK;
            idx_q       <= 3'd7;
            presc_q     <= '0;
            blank_q     <= '0;
            blink_q     <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            pend_full_q <= 1'b0;
            load_ack_q  <= 1'b0;
            an_q        <= 8'hFF;
            cath_q      <= 7'h7F;
            dp_q        <= 1'b1;
            fs_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            presc_q    <= presc_d;
            blank_q    <= blank_d;
            blink_q    <= blink_q + 1'b1;
            load_ack_q <= capture;
            if (commit) begin
                active_q    <= pending_q;
                pend_full_q <= 1'b0;
            end else if (capture) begin
                pending_q   <= load_in;
                pend_full_q <= 1'b1;
            end
            an_q   <= an_d;
            cath_q <= cath_d;
            dp_q   <= dp_d;
            fs_q   <= fs_d;
        end
    end

    assign An           = an_q;
    assign Cath         = cath_q;
    assign Dp           = dp_q;
    assign frame_start  = fs_q;
    assign ld.load_ack  = load_ack_q;
    assign ld.dbg_state = state_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Self-checking bench for ssd_scan_controller: frame-arithmetic reference model, randomized content.
module tb_ssd_scan_controller;

    localparam int SCAN_DIV_W   = 4;
    localparam int BLANK_CYCLES = 2;
    localparam int BLINK_DIV_W  = 8;
    localparam int SLOT         = (1 << SCAN_DIV_W) + BLANK_CYCLES;
    localparam int FRAME        = 8 * SLOT;
    localparam int BLINK_PERIOD = 1 << BLINK_DIV_W;
    localparam logic [17:0] RST_V = {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0};

    typedef struct packed {
        logic [31:0] dig;
        logic [7:0]  en;
        logic [7:0]  dp;
        logic [7:0]  bm;
    } content_t;

    logic ClkPort = 1'b0;
    logic reset   = 1'b1;
    logic blink_en = 1'b0;
    wire [7:0] An;
    wire [6:0] Cath;
    wire       Dp;
    wire       frame_start;
`ifdef SSD_DIMMING_EN
    logic [2:0] brightness = 3'd7;
`endif

    ssd_scan_controller_if ld();

    ssd_scan_controller #(
        .SCAN_DIV_W   (SCAN_DIV_W),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_DIV_W  (BLINK_DIV_W)
    ) dut (
        .ClkPort     (ClkPort),
        .reset       (reset),
        .ld          (ld),
        .blink_en    (blink_en),
`ifdef SSD_DIMMING_EN
        .brightness  (brightness),
`endif
        .An          (An),
        .Cath        (Cath),
        .Dp          (Dp),
        .frame_start (frame_start)
    );

    always #5 ClkPort = ~ClkPort;

    // Segment table written straight from the display's character chart.
    logic [6:0] hex_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int checks = 0;
    int errors = 0;

    // Reference model: kk counts clock edges since reset release; the scan position
    // follows from kk by plain frame arithmetic.
    int          kk;
    content_t    m_act, m_pend;
    bit          m_pfull;
    logic [17:0] exp_v;
    wire  [17:0] obs_v = {An, Cath, Dp, frame_start, ld.load_ack};

    function automatic logic [17:0] expect_out(input int j, input content_t c, input logic be);
        int m, slot, r;
        logic lit;
        logic [7:0] an;
        logic [3:0] nib;
        m    = j % FRAME;
        slot = m / SLOT;
        r    = m % SLOT;
        nib  = c.dig[slot*4 +: 4];
        lit  = (r >= BLANK_CYCLES) && c.en[slot] &&
               !(be && c.bm[slot] && ((j % BLINK_PERIOD) >= BLINK_PERIOD / 2));
        an = 8'hFF;
        if (lit) an[slot] = 1'b0;
        return {an, lit ? hex_tab[nib] : 7'h7F, lit ? ~c.dp[slot] : 1'b1, (m == BLANK_CYCLES), 1'b0};
    endfunction

    task automatic model_reset();
        kk      = 0;
        m_act   = '0;
        m_pend  = '0;
        m_pfull = 1'b0;
    endtask

    task automatic model_edge();
        bit cap, com;
        exp_v = expect_out(kk, m_act, blink_en);
        cap = ld.load_req && !m_pfull;
        com = (((kk + 1) % FRAME) == BLANK_CYCLES) && m_pfull;
        if (com) begin
            m_act   = m_pend;
            m_pfull = 1'b0;
        end
        if (cap) begin
            m_pend  = {ld.digits_in, ld.digit_en_in, ld.dp_in, ld.blink_mask_in};
            m_pfull = 1'b1;
        end
        exp_v[0] = cap;
        kk++;
    endtask

    // One clock: advance the model, settle, and release load_req once acked.
    task automatic tick();
        @(posedge ClkPort);
        model_edge();
        #1;
        if (ld.load_ack) ld.load_req = 1'b0;
    endtask

    task automatic start_load(input content_t c);
        ld.digits_in     = c.dig;
        ld.digit_en_in   = c.en;
        ld.dp_in         = c.dp;
        ld.blink_mask_in = c.bm;
        ld.load_req      = 1'b1;
    endtask

    task automatic wait_ack(input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (ld.load_ack) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    function automatic content_t rand_content(input logic [7:0] en, input logic [7:0] bm);
        content_t c;
        c.dig = $urandom;
        c.en  = en;
        c.dp  = 8'($urandom_range(0, 255));
        c.bm  = bm;
        return c;
    endfunction

    task automatic test_reset();
        int fs_cnt, last_fs, first_fs;
        reset = 1'b1;
        ld.load_req = 1'b0;
        ld.digits_in = '0; ld.digit_en_in = '0; ld.dp_in = '0; ld.blink_mask_in = '0;
        repeat (3) @(posedge ClkPort);
        #1;
        checks++;
        if (obs_v !== RST_V) begin
            errors++; $display("FAIL reset_values got %h exp %h", obs_v, RST_V);
        end
        @(negedge ClkPort);
        reset = 1'b0;
        model_reset();
        fs_cnt = 0; last_fs = -1; first_fs = -1;
        for (int i = 0; i < 300; i++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL reset_idle cyc %0d got %h exp %h", kk, obs_v, exp_v);
            end
            if (frame_start) begin
                if (first_fs < 0) first_fs = kk;
                if (last_fs >= 0) begin
                    checks++;
                    if (kk - last_fs != FRAME) begin
                        errors++; $display("FAIL frame_period got %0d exp %0d", kk - last_fs, FRAME);
                    end
                end
                last_fs = kk;
                fs_cnt++;
            end
        end
        checks++;
        if (first_fs != BLANK_CYCLES + 1) begin
            errors++; $display("FAIL first_frame_start got %0d exp %0d", first_fs, BLANK_CYCLES + 1);
        end
        checks++;
        if (fs_cnt != 3) begin
            errors++; $display("FAIL frame_start_count got %0d exp 3", fs_cnt);
        end
    endtask

    task automatic test_load_basic();
        content_t c;
        bit found;
        int pre_lit;
        logic [15:0] want, got;
        c = '{dig: 32'h7654_3210, en: 8'hFF, dp: 8'h01, bm: 8'h00};
        start_load(c);
        tick();
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL load_first_cycle got %h exp %h", obs_v, exp_v);
        end
        checks++;
        if (ld.load_ack !== 1'b1) begin
            errors++; $display("FAIL load_ack_latency got %b exp 1", ld.load_ack);
        end
        found = 1'b0; pre_lit = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL load_wait cyc %0d got %h exp %h", kk, obs_v, exp_v);
            end
            if (frame_start) begin
                found = 1'b1;
                break;
            end
            if (An !== 8'hFF) pre_lit++;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL load_commit_timeout got none exp frame_start");
        end
        checks++;
        if (pre_lit != 0) begin
            errors++; $display("FAIL load_before_commit got %0d lit cycles exp 0", pre_lit);
        end
        for (int off = 0; off <= SLOT; off++) begin
            if (off > 0) begin
                tick();
                checks++;
                if (obs_v !== exp_v) begin
                    errors++; $display("FAIL load_slot cyc %0d got %h exp %h", kk, obs_v, exp_v);
                end
            end
            if (off < 16)       want = {8'hFE, 7'b0000001, 1'b0};
            else if (off < 18)  want = {8'hFF, 7'h7F, 1'b1};
            else                want = {8'hFD, 7'b1001111, 1'b1};
            got = {An, Cath, Dp};
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL load_digit_timing off %0d got %h exp %h", off, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        content_t ca, cb;
        bit got;
        int fs_before, tear, lit_seen, slot;
        logic [6:0] want_c;
        ca = rand_content(8'hFF, 8'h00);
        cb = rand_content(8'hFF, 8'h00);
        start_load(ca);
        wait_ack(10, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL b2b_first_ack got none exp ack");
        end
        start_load(cb);
        got = 1'b0; fs_before = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL b2b_wait cyc %0d got %h exp %h", kk, obs_v, exp_v);
            end
            if (ld.load_ack) begin
                got = 1'b1;
                checks++;
                if (frame_start !== 1'b1) begin
                    errors++; $display("FAIL b2b_ack_at_commit got fs=%b exp 1", frame_start);
                end
                break;
            end
            if (frame_start) fs_before++;
        end
        checks++;
        if (!got || fs_before != 0) begin
            errors++; $display("FAIL b2b_second_ack got ack=%b fs_before=%0d exp ack=1 fs_before=0", got, fs_before);
        end
        // The frame that starts with the second ack must show only the first content.
        tear = 0; lit_seen = 0;
        for (int off = 0; off < FRAME; off++) begin
            if (off > 0) begin
                tick();
                checks++;
                if (obs_v !== exp_v) begin
                    errors++; $display("FAIL b2b_frame cyc %0d got %h exp %h", kk, obs_v, exp_v);
                end
            end
            if (An !== 8'hFF) begin
                slot = 0;
                for (int d = 0; d < 8; d++) if (An[d] == 1'b0) slot = d;
                want_c = hex_tab[ca.dig[slot*4 +: 4]];
                if (Cath !== want_c) tear++;
                lit_seen++;
            end
        end
        checks++;
        if (tear != 0 || lit_seen != 8 * 16) begin
            errors++; $display("FAIL b2b_no_tearing got tear=%0d lit=%0d exp tear=0 lit=128", tear, lit_seen);
        end
    endtask

    task automatic test_sparse_enable();
        content_t c;
        bit armed, active;
        int even_low, odd_low, last_fs;
        c = rand_content(8'b1010_1010, 8'h00);
        start_load(c);
        armed = 1'b0; active = 1'b0; even_low = 0; odd_low = 0; last_fs = -1;
        for (int i = 0; i < 4 * FRAME + 20; i++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL sparse cyc %0d got %h exp %h", kk, obs_v, exp_v);
            end
            if (frame_start && armed) begin
                if (active) begin
                    checks++;
                    if (kk - last_fs != FRAME) begin
                        errors++; $display("FAIL sparse_frame_period got %0d exp %0d", kk - last_fs, FRAME);
                    end
                end
                active = 1'b1;
                last_fs = kk;
            end
            if (ld.load_ack) armed = 1'b1;
            if (active) begin
                if (((~An) & 8'h55) != 8'h00) even_low++;
                if (((~An) & 8'hAA) != 8'h00) odd_low++;
            end
        end
        checks++;
        if (!active || even_low != 0 || odd_low == 0) begin
            errors++; $display("FAIL sparse_anodes got active=%b even=%0d odd=%0d exp 1/0/>0", active, even_low, odd_low);
        end
    endtask

    task automatic test_blink();
        content_t c;
        bit armed, active;
        int dark0, lit0, odd0;
        blink_en = 1'b1;
        c = rand_content(8'hFF, 8'h01);
        start_load(c);
        armed = 1'b0; active = 1'b0; dark0 = 0; lit0 = 0; odd0 = 0;
        for (int i = 0; i < 1300; i++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL blink cyc %0d got %h exp %h", kk, obs_v, exp_v);
            end
            if (frame_start && armed) active = 1'b1;
            if (ld.load_ack) armed = 1'b1;
            if (active && frame_start) begin
                if (An === 8'hFF)      dark0++;
                else if (An === 8'hFE) lit0++;
                else                   odd0++;
            end
        end
        checks++;
        if (dark0 == 0 || lit0 == 0 || odd0 != 0) begin
            errors++; $display("FAIL blink_digit0 got dark=%0d lit=%0d other=%0d exp >0/>0/0", dark0, lit0, odd0);
        end
        blink_en = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        content_t c;
        bit got;
        int lit_after, first_fs;
        for (int i = 0; i < 2 * FRAME && (kk % FRAME) != BLANK_CYCLES; i++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL rst_align cyc %0d got %h exp %h", kk, obs_v, exp_v);
            end
        end
        c = rand_content(8'hFF, 8'h00);
        start_load(c);
        wait_ack(4, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL rst_pending_ack got none exp ack");
        end
        for (int i = 0; i < 2 * FRAME && (kk % FRAME) != 3 * SLOT + BLANK_CYCLES + 8; i++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL rst_to_digit3 cyc %0d got %h exp %h", kk, obs_v, exp_v);
            end
        end
        checks++;
        if (An !== 8'hF7) begin
            errors++; $display("FAIL rst_digit3_driven got %h exp f7", An);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs_v !== RST_V) begin
            errors++; $display("FAIL rst_mid_scan_outputs got %h exp %h", obs_v, RST_V);
        end
        repeat (2) @(posedge ClkPort);
        @(negedge ClkPort);
        reset = 1'b0;
        model_reset();
        lit_after = 0; first_fs = -1;
        for (int i = 0; i < 150; i++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL rst_after cyc %0d got %h exp %h", kk, obs_v, exp_v);
            end
            if (An !== 8'hFF) lit_after++;
            if (frame_start && first_fs < 0) first_fs = kk;
        end
        checks++;
        if (lit_after != 0 || first_fs != BLANK_CYCLES + 1) begin
            errors++; $display("FAIL rst_after_blank got lit=%0d fs_at=%0d exp 0/%0d", lit_after, first_fs, BLANK_CYCLES + 1);
        end
        c = rand_content(8'hFF, 8'h00);
        start_load(c);
        tick();
        checks++;
        if (ld.load_ack !== 1'b1) begin
            errors++; $display("FAIL rst_pending_discarded got ack=%b exp 1", ld.load_ack);
        end
        for (int i = 0; i < 200; i++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL rst_reload cyc %0d got %h exp %h", kk, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        model_reset();
        exp_v = RST_V;
        test_reset();
        test_load_basic();
        test_back_to_back();
        test_sparse_enable();
        test_blink();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
